// File: rtl/xgriscv_mdu_if.sv
// xgriscv_mdu_if: request/response bundle between the execute stage and the
// multiply/divide unit.
//   master (core side): drives valid_i, PreALUop, funct7, funct3, a_i, b_i,
//                       flush_i; observes is_m_o, stall_o, busy_o, done_o,
//                       result_o.
//   slave  (MDU side) : the inverse.
interface xgriscv_mdu_if #(
    parameter int XLEN = 32
);
    logic            valid_i;
    logic [1:0]      PreALUop;
    logic [6:0]      funct7;
    logic [2:0]      funct3;
    logic [XLEN-1:0] a_i;
    logic [XLEN-1:0] b_i;
    logic            flush_i;
    logic            is_m_o;
    logic            stall_o;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output valid_i, PreALUop, funct7, funct3, a_i, b_i, flush_i,
        input  is_m_o, stall_o, busy_o, done_o, result_o
    );

    modport slave (
        input  valid_i, PreALUop, funct7, funct3, a_i, b_i, flush_i,
        output is_m_o, stall_o, busy_o, done_o, result_o
    );
endinterface

// File: rtl/xgriscv_mdu.sv
// xgriscv_mdu: multi-cycle RV32M/RV64M multiply/divide unit.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : xgriscv_mdu_if slave port
//     valid_i/PreALUop/funct7/funct3/a_i/b_i : instruction in execute
//     flush_i  : synchronous abort; drops any operation in flight
//     is_m_o   : combinational M-group decode
//     stall_o  : holds the pipeline while a result is pending
//     busy_o   : iterating (CALC)
//     done_o   : one-cycle result-valid pulse
//     result_o : registered result, held until the next one is written
// Multiplies use a shift-add loop over a 2*XLEN accumulator ({hi, multiplier});
// divides use a restoring loop over the same accumulator ({remainder, quotient}).
// Both operate on magnitudes; the result sign is applied in the final cycle.
module xgriscv_mdu #(
    parameter int XLEN     = 32,
    parameter bit FAST_MUL = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    xgriscv_mdu_if.slave  bus
);

    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_t;

    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state;
    op_t               op_q;
    logic              neg_q;
    logic [CW-1:0]     counter;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opb;
    logic [XLEN-1:0]   result_q;
    logic              done_q;
    logic              busy_q;

    logic              is_m;
    op_t               cur_op;
    logic              cur_mul;
    logic              cur_rem;
    logic              a_signed;
    logic              b_signed;
    logic              sa;
    logic              sb;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic              neg_d;
    logic [2*XLEN-1:0] fast_prod;
    logic              short_hit;
    logic [XLEN-1:0]   short_val;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] step_acc;
    logic [2*XLEN-1:0] prod_signed;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   final_res;

    assign is_m         = (bus.PreALUop == 2'b10) && (bus.funct7 == 7'b0000001);
    assign bus.is_m_o   = is_m;
    assign bus.stall_o  = ((state == IDLE) && bus.valid_i && is_m) || (state == CALC);
    assign bus.busy_o   = busy_q;
    assign bus.done_o   = done_q;
    assign bus.result_o = result_q;

    // Operand preparation at acceptance: magnitudes, result sign, short-circuits.
    always_comb begin
        cur_op    = op_t'(bus.funct3);
        cur_mul   = ~bus.funct3[2];
        cur_rem   = bus.funct3[2] & bus.funct3[1];
        a_signed  = (cur_op == OP_MULH) || (cur_op == OP_MULHSU) ||
                    (cur_op == OP_DIV)  || (cur_op == OP_REM);
        b_signed  = (cur_op == OP_MULH) || (cur_op == OP_DIV) || (cur_op == OP_REM);
        sa        = a_signed & bus.a_i[XLEN-1];
        sb        = b_signed & bus.b_i[XLEN-1];
        mag_a     = sa ? (~bus.a_i + 1'b1) : bus.a_i;
        mag_b     = sb ? (~bus.b_i + 1'b1) : bus.b_i;
        // Remainder takes the dividend's sign; product and quotient take sa^sb.
        neg_d     = cur_rem ? sa : (sa ^ sb);
        fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
        if (neg_d) begin
            fast_prod = ~fast_prod + 1'b1;
        end

        short_hit = 1'b0;
        short_val = '0;
        if (!cur_mul && (bus.b_i == '0)) begin
            short_hit = 1'b1;
            short_val = bus.funct3[1] ? bus.a_i : '1;
        end else if (((cur_op == OP_DIV) || (cur_op == OP_REM)) &&
                     (bus.a_i == MIN_INT) && (bus.b_i == '1)) begin
            short_hit = 1'b1;
            short_val = bus.funct3[1] ? '0 : MIN_INT;
        end else if (FAST_MUL && cur_mul) begin
            short_hit = 1'b1;
            short_val = (cur_op == OP_MUL) ? fast_prod[XLEN-1:0]
                                           : fast_prod[2*XLEN-1:XLEN];
        end
    end

    // One iteration step, plus the signed/selected result of the last step.
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
        div_shift = acc[2*XLEN-1:XLEN-1];
        div_diff  = div_shift - {1'b0, opb};
        step_acc  = acc;
        if (!op_q[2]) begin
            step_acc = {mul_sum, acc[XLEN-1:1]};
        end else if (!div_diff[XLEN]) begin
            step_acc = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end else begin
            step_acc = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end

        prod_signed = neg_q ? (~step_acc + 1'b1) : step_acc;
        quo         = neg_q ? (~step_acc[XLEN-1:0] + 1'b1) : step_acc[XLEN-1:0];
        rem         = neg_q ? (~step_acc[2*XLEN-1:XLEN] + 1'b1) : step_acc[2*XLEN-1:XLEN];
        final_res   = '0;
        case (op_q)
            OP_MUL:                       final_res = prod_signed[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_signed[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              final_res = quo;
            default:                      final_res = rem;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            op_q     <= OP_MUL;
            neg_q    <= 1'b0;
            counter  <= '0;
            acc      <= '0;
            opb      <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.valid_i && is_m && !bus.flush_i) begin
                        op_q  <= cur_op;
                        neg_q <= neg_d;
                        if (short_hit) begin
                            result_q <= short_val;
                            done_q   <= 1'b1;
                            state    <= DONE;
                        end else begin
                            acc     <= {{XLEN{1'b0}}, mag_a};
                            opb     <= mag_b;
                            counter <= CW'(XLEN);
                            busy_q  <= 1'b1;
                            state   <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (bus.flush_i) begin
                        counter <= '0;
                        busy_q  <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        counter <= counter - 1'b1;
                        acc     <= step_acc;
                        if (counter == CW'(1)) begin
                            result_q <= final_res;
                            done_q   <= 1'b1;
                            busy_q   <= 1'b0;
                            state    <= DONE;
                        end
                    end
                end
                default: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xgriscv_mdu.sv
module tb_xgriscv_mdu;

    typedef struct {
        string       name;
        logic [31:0] res;
        int          due;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   total;
    int   bad;
    exp_t sq[$];
    exp_t fq[$];

    xgriscv_mdu_if #(.XLEN(32)) sif ();
    xgriscv_mdu_if #(.XLEN(32)) fif ();

    xgriscv_mdu #(.XLEN(32), .FAST_MUL(1'b0)) u_slow (.clk(clk), .reset(reset), .bus(sif));
    xgriscv_mdu #(.XLEN(32), .FAST_MUL(1'b1)) u_fast (.clk(clk), .reset(reset), .bus(fif));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: every done pulse is matched against the queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (sif.done_o) begin
            if (sq.size() == 0) begin
                check("slow_unexpected_done", 64'(sif.result_o), 64'hDEAD_0000_0000_0000);
            end else begin
                e = sq.pop_front();
                check({e.name, "_result"}, 64'(sif.result_o), 64'(e.res));
                check({e.name, "_cycle"}, 64'(cyc), 64'(e.due));
            end
        end
        if (fif.done_o) begin
            if (fq.size() == 0) begin
                check("fast_unexpected_done", 64'(fif.result_o), 64'hDEAD_0000_0000_0000);
            end else begin
                e = fq.pop_front();
                check({e.name, "_result"}, 64'(fif.result_o), 64'(e.res));
                check({e.name, "_cycle"}, 64'(cyc), 64'(e.due));
            end
        end
    end

    task automatic drive(input bit fast, input logic v, input logic [1:0] pre,
                         input logic [6:0] f7, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b);
        if (fast) begin
            fif.valid_i = v; fif.PreALUop = pre; fif.funct7 = f7;
            fif.funct3 = f3; fif.a_i = a; fif.b_i = b;
        end else begin
            sif.valid_i = v; sif.PreALUop = pre; sif.funct7 = f7;
            sif.funct3 = f3; sif.a_i = a; sif.b_i = b;
        end
    endtask

    // Issues one M-op, queues its expectation, and counts stall cycles until done.
    // With noise set, junk requests are driven on the port while the op is in flight.
    task automatic run_op(input string nm, input bit fast, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input int lat, input bit noise);
        exp_t e;
        int   stalls;
        bit   seen;
        e.name = nm; e.res = res; e.due = cyc + lat;
        if (fast) fq.push_back(e); else sq.push_back(e);
        drive(fast, 1'b1, 2'b10, 7'b0000001, f3, a, b);
        stalls = 0;
        seen = 1'b0;
        @(negedge clk);
        stalls += int'(fast ? fif.stall_o : sif.stall_o);
        @(posedge clk); #1;
        drive(fast, 1'b0, 2'b10, 7'b0000001, f3, a, b);
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (fast ? fif.done_o : sif.done_o) begin
                seen = 1'b1;
                break;
            end
            stalls += int'(fast ? fif.stall_o : sif.stall_o);
            if (noise) drive(fast, k[0], 2'b10, 7'b0000001, 3'b101, 32'(k), 32'd0);
        end
        drive(fast, 1'b0, 2'b10, 7'b0000001, 3'b000, 32'd0, 32'd0);
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s_timeout got=no_done want=done", nm);
        end
        check({nm, "_stall_cycles"}, 64'(stalls), 64'(lat));
        @(posedge clk); #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        sif.flush_i = 1'b0;
        fif.flush_i = 1'b0;
        drive(1'b0, 1'b0, 2'b00, 7'd0, 3'd0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 2'b00, 7'd0, 3'd0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk); #1;

        check("rst_result", 64'(sif.result_o), 64'd0);
        check("rst_done",   64'(sif.done_o),   64'd0);
        check("rst_busy",   64'(sif.busy_o),   64'd0);
        check("rst_stall",  64'(sif.stall_o),  64'd0);

        // Iterative multiplies and divides
        run_op("mul_7_m3",    1'b0, 3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 1'b0);
        run_op("mulh_min",    1'b0, 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 1'b0);
        run_op("mulhu_ones",  1'b0, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1'b0);
        run_op("mulhsu_m1_2", 1'b0, 3'b010, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 33, 1'b0);
        run_op("div_m7_2",    1'b0, 3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33, 1'b0);
        run_op("rem_m7_2",    1'b0, 3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33, 1'b0);
        run_op("divu_100_7",  1'b0, 3'b101, 32'd100,       32'd7,        32'd14,        33, 1'b0);
        run_op("remu_100_7",  1'b0, 3'b111, 32'd100,       32'd7,        32'd2,         33, 1'b0);

        // Short-circuit cases
        run_op("divu_by0",    1'b0, 3'b101, 32'd5,         32'd0,        32'hFFFF_FFFF, 1, 1'b0);
        run_op("rem_by0",     1'b0, 3'b110, 32'd5,         32'd0,        32'd5,         1, 1'b0);
        run_op("div_ovf",     1'b0, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0);
        run_op("rem_ovf",     1'b0, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1, 1'b0);

        // Flush mid-divide: no done pulse, pipeline released the following cycle
        drive(1'b0, 1'b1, 2'b10, 7'b0000001, 3'b101, 32'd100, 32'd7);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 2'b10, 7'b0000001, 3'b000, 32'd0, 32'd0);
        repeat (9) @(posedge clk);
        #1 sif.flush_i = 1'b1;
        @(posedge clk); #1;
        sif.flush_i = 1'b0;
        check("flush_busy",  64'(sif.busy_o),  64'd0);
        check("flush_stall", 64'(sif.stall_o), 64'd0);
        repeat (40) @(posedge clk);
        #1;
        run_op("mul_3_4", 1'b0, 3'b000, 32'd3, 32'd4, 32'd12, 33, 1'b0);

        // Async reset during CALC, checked without an intervening clock edge
        drive(1'b0, 1'b1, 2'b10, 7'b0000001, 3'b000, 32'd9, 32'd9);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 2'b10, 7'b0000001, 3'b000, 32'd0, 32'd0);
        repeat (5) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_result", 64'(sif.result_o), 64'd0);
        check("arst_busy",   64'(sif.busy_o),   64'd0);
        check("arst_stall",  64'(sif.stall_o),  64'd0);
        #1 reset = 1'b0;
        repeat (40) @(posedge clk);
        #1;

        // Non-M instruction: no decode, no stall, no operation
        drive(1'b0, 1'b1, 2'b10, 7'b0000000, 3'b000, 32'd5, 32'd6);
        #1;
        check("nonm_is_m",  64'(sif.is_m_o),  64'd0);
        check("nonm_stall", 64'(sif.stall_o), 64'd0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 2'b10, 7'b0000001, 3'b000, 32'd0, 32'd0);
        check("nonm_busy", 64'(sif.busy_o), 64'd0);
        repeat (40) @(posedge clk);
        #1;

        // Requests during CALC are ignored and operands stay latched
        run_op("mul_noise", 1'b0, 3'b000, 32'd11, 32'd13, 32'd143, 33, 1'b1);

        // Single-cycle multiplier build
        run_op("fast_mul_6_7",  1'b1, 3'b000, 32'd6,         32'd7,         32'd42,        1, 1'b0);
        run_op("fast_mulh_min", 1'b1, 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1, 1'b0);
        run_op("fast_divu",     1'b1, 3'b101, 32'd100,       32'd7,         32'd14,        33, 1'b0);

        repeat (5) @(posedge clk);
        check("sb_slow_empty", 64'(sq.size()), 64'd0);
        check("sb_fast_empty", 64'(fq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
